// File: rtl/bus_arbiter_ctrl.sv
// bus_arbiter_ctrl
// Arbitrates NUM_CH source channels onto the shared register-map address/data
// path and routes register-map readback to the channel served last.
//   - Round-robin grant among requesting channels, readback has priority.
//   - Write transaction: IDLE -> ADDR -> DATA -> WRITE -> IDLE.
//   - Readback:          IDLE -> RB_ACK -> RB_XFER -> IDLE.
//   - All outputs are registered except busy, which is decoded from state.
// Optional feature macro: BUS_ACTIVITY_LED_EN
//   When defined, led stays high for LED_HOLD cycles after every WRITE or
//   RB_XFER cycle, retriggering on new activity. When undefined, led is tied
//   low and no counter exists.
//
// Handshake: ch_avail is a level request sampled only in IDLE; a granted
// channel presents its address word while its ch_out bit is high in ADDR and
// its data word while the bit is high in DATA. regmap_avail is a level sampled
// only in IDLE; regmap_rdata must be valid during the RB_ACK cycle (the cycle
// regmap_out is high), after which the register map may drop regmap_avail.

module bus_arbiter_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LED_HOLD = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_avail,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_out,
  output logic [NUM_CH-1:0]        ch_in,
  output logic [DATA_W-1:0]        ch_tx_data,
  output logic [ADDR_W-1:0]        addr_bus,
  output logic [DATA_W-1:0]        wdata,
  output logic                     regmap_in,
  output logic                     regmap_out,
  input  logic                     regmap_avail,
  input  logic [DATA_W-1:0]        regmap_rdata,
  output logic                     busy,
  output logic                     led
);

  // Width of a channel index; at least one bit so NUM_CH=1 still elaborates.
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Reject parameter sets the datapath cannot represent.
  if (NUM_CH < 1 || NUM_CH > 8 || ADDR_W > DATA_W || LED_HOLD < 1) begin : g_param_check
    $error("bus_arbiter_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    WRITE   = 3'd3,
    RB_ACK  = 3'd4,
    RB_XFER = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;

  // last_grant is the channel currently (or most recently) being served;
  // rb_ch is the readback destination and follows every new grant.
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     rb_ch;
  logic [GW-1:0]     grant_idx;
  logic [GW-1:0]     rr_cand;
  logic              grant_found;
  logic              take_grant;

  logic [DATA_W-1:0] ch_word [NUM_CH];
  logic [DATA_W-1:0] sel_word;
  logic [ADDR_W-1:0] addr_cap;

  function automatic logic [NUM_CH-1:0] onehot(input logic [GW-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

  // Unflatten the per-channel data bus and select the granted channel's word.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_word[i] = ch_data[i*DATA_W +: DATA_W];
    end
    sel_word = ch_word[last_grant];
  end

  // Round-robin search: first requesting channel after last_grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_cand     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_cand = GW'((int'(last_grant) + k) % NUM_CH);
      if (!grant_found && ch_avail[rr_cand]) begin
        grant_found = 1'b1;
        grant_idx   = rr_cand;
      end
    end
  end

  // A grant is only taken in IDLE when no readback is pending.
  assign take_grant = (state_q == IDLE) && !regmap_avail && grant_found;

  // Next-state logic: fixed-length transactions, readback wins over writes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (regmap_avail) begin
          state_d = RB_ACK;
        end else if (grant_found) begin
          state_d = ADDR;
        end
      end
      ADDR:    state_d = DATA;
      DATA:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      RB_ACK:  state_d = RB_XFER;
      RB_XFER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q != IDLE);

  // Grant bookkeeping; after reset the search starts at channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GW'(NUM_CH - 1);
      rb_ch      <= '0;
    end else if (take_grant) begin
      last_grant <= grant_idx;
      rb_ch      <= grant_idx;
    end
  end

  // Strobes are registered from the next state so each is high for exactly
  // the cycle spent in its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_out     <= '0;
      ch_in      <= '0;
      regmap_in  <= 1'b0;
      regmap_out <= 1'b0;
    end else begin
      ch_out     <= '0;
      ch_in      <= '0;
      regmap_in  <= (state_d == WRITE);
      regmap_out <= (state_d == RB_ACK);
      if (state_d == ADDR) begin
        ch_out <= onehot(grant_idx);
      end else if (state_d == DATA) begin
        ch_out <= onehot(last_grant);
      end
      if (state_d == RB_XFER) begin
        ch_in <= onehot(rb_ch);
      end
    end
  end

  // Datapath capture: address at end of ADDR, data (and the visible address)
  // at end of DATA so both appear together in WRITE; readback at end of RB_ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cap   <= '0;
      addr_bus   <= '0;
      wdata      <= '0;
      ch_tx_data <= '0;
    end else begin
      if (state_q == ADDR) begin
        addr_cap <= sel_word[ADDR_W-1:0];
      end
      if (state_q == DATA) begin
        addr_bus <= addr_cap;
        wdata    <= sel_word;
      end
      if (state_q == RB_ACK) begin
        ch_tx_data <= regmap_rdata;
      end
    end
  end

`ifdef BUS_ACTIVITY_LED_EN
  localparam int LW = $clog2(LED_HOLD + 1);

  logic [LW-1:0] led_cnt;
  logic [LW-1:0] led_cnt_d;

  // Reload on every completed transaction, otherwise count down to zero.
  always_comb begin
    led_cnt_d = led_cnt;
    if (state_q == WRITE || state_q == RB_XFER) begin
      led_cnt_d = LW'(LED_HOLD);
    end else if (led_cnt != '0) begin
      led_cnt_d = led_cnt - LW'(1);
    end
  end

  // LED register follows the next count so it rises the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_cnt <= '0;
      led     <= 1'b0;
    end else begin
      led_cnt <= led_cnt_d;
      led     <= (led_cnt_d != '0);
    end
  end
`else
  assign led = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// tb_bus_arbiter_ctrl
// Directed bench for bus_arbiter_ctrl (NUM_CH=2, 8-bit paths, LED_HOLD=4).
// Channel and register-map models react at the falling edge; the main
// sequence drives requests and samples outputs 1 ns after the falling edge.
// Expected writes and readbacks go into queues and are retired when the DUT
// strobes regmap_in / ch_in.

module tb_bus_arbiter_ctrl;

  localparam int NUM_CH   = 2;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int LED_HOLD = 4;
  localparam int EW       = 4 + ADDR_W + DATA_W;

`ifdef BUS_ACTIVITY_LED_EN
  localparam bit LED_ON = 1'b1;
`else
  localparam bit LED_ON = 1'b0;
`endif

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_avail;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_out;
  logic [NUM_CH-1:0]        ch_in;
  logic [DATA_W-1:0]        ch_tx_data;
  logic [ADDR_W-1:0]        addr_bus;
  logic [DATA_W-1:0]        wdata;
  logic                     regmap_in;
  logic                     regmap_out;
  logic                     regmap_avail;
  logic [DATA_W-1:0]        regmap_rdata;
  logic                     busy;
  logic                     led;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] rb_q[$];
  int            wr_times[$];

  int                in_cnt [NUM_CH];
  int                last_out_ch;
  logic [ADDR_W-1:0] cur_addr [NUM_CH];
  logic [DATA_W-1:0] cur_data [NUM_CH];
  bit                ph [NUM_CH];
  bit                rb_scramble;

  bus_arbiter_ctrl #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LED_HOLD(LED_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_avail    (ch_avail),
    .ch_data     (ch_data),
    .ch_out      (ch_out),
    .ch_in       (ch_in),
    .ch_tx_data  (ch_tx_data),
    .addr_bus    (addr_bus),
    .wdata       (wdata),
    .regmap_in   (regmap_in),
    .regmap_out  (regmap_out),
    .regmap_avail(regmap_avail),
    .regmap_rdata(regmap_rdata),
    .busy        (busy),
    .led         (led)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int ch, input logic [ADDR_W-1:0] a,
                                       input logic [DATA_W-1:0] d);
    return {4'(ch), a, d};
  endfunction

  // Advance to the sample/drive point of the next cycle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy",       32'(busy),       0);
    check("rst_ch_out",     32'(ch_out),     0);
    check("rst_ch_in",      32'(ch_in),      0);
    check("rst_regmap_in",  32'(regmap_in),  0);
    check("rst_regmap_out", 32'(regmap_out), 0);
    check("rst_addr_bus",   32'(addr_bus),   0);
    check("rst_wdata",      32'(wdata),      0);
    check("rst_ch_tx_data", 32'(ch_tx_data), 0);
    check("rst_led",        32'(led),        0);
    rst = 1'b0;
    wr_times.delete();
  endtask

  // ---------------- channel / register-map models and monitor ----------------
  initial begin
    ch_data     = '0;
    rb_scramble = 1'b0;
    last_out_ch = -1;
    for (int i = 0; i < NUM_CH; i++) begin
      in_cnt[i] = 0;
      ph[i]     = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      // Channels: address word on the first ch_out cycle, data word on the
      // second, then advance to the next word pair. Noise otherwise.
      for (int i = 0; i < NUM_CH; i++) begin
        if (rst) ph[i] = 1'b0;
        if (ch_out[i]) begin
          if (!ph[i]) begin
            ch_data[i*DATA_W +: DATA_W] = DATA_W'(cur_addr[i]);
          end else begin
            ch_data[i*DATA_W +: DATA_W] = cur_data[i];
            cur_addr[i] = cur_addr[i] + 1'b1;
            cur_data[i] = cur_data[i] + 1'b1;
          end
          ph[i] = !ph[i];
        end else begin
          ch_data[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
        end
      end
      // Register map: drop the request once acknowledged, then scramble data.
      if (rb_scramble) begin
        regmap_rdata = DATA_W'($urandom_range(0, 255));
        rb_scramble  = 1'b0;
      end
      if (regmap_out) begin
        regmap_avail = 1'b0;
        rb_scramble  = 1'b1;
      end
      // Monitor.
      check("ch_out_onehot0", 32'($countones(ch_out) <= 1), 1);
      check("ch_in_onehot0",  32'($countones(ch_in) <= 1),  1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_out[i]) last_out_ch = i;
        if (ch_in[i])  in_cnt[i]++;
      end
      if (regmap_in) begin
        wr_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("wr_ch",   32'(last_out_ch), 32'(e[EW-1 -: 4]));
          check("wr_addr", 32'(addr_bus),    32'(e[ADDR_W+DATA_W-1 -: ADDR_W]));
          check("wr_data", 32'(wdata),       32'(e[DATA_W-1:0]));
        end
      end
      if (ch_in != '0) begin
        if (rb_q.size() == 0) begin
          check("rb_unexpected", 1, 0);
        end else begin
          logic [EW-1:0] e;
          int            idx;
          e   = rb_q.pop_front();
          idx = -1;
          for (int i = 0; i < NUM_CH; i++) if (ch_in[i]) idx = i;
          check("rb_ch",   32'(idx),        32'(e[EW-1 -: 4]));
          check("rb_data", 32'(ch_tx_data), 32'(e[DATA_W-1:0]));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    int c0;
    int c1;
    rst          = 1'b1;
    ch_avail     = '0;
    regmap_avail = 1'b0;
    regmap_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cur_addr[i] = '0;
      cur_data[i] = '0;
    end
    do_reset();

    // 1: single write on channel 0.
    cur_addr[0] = 8'h12;
    cur_data[0] = 8'hA5;
    exp_q.push_back(mk(0, 8'h12, 8'hA5));
    ch_avail = 2'b01;
    t0 = cyc;
    tick();
    check("t1_busy_addr",  32'(busy),      1);
    check("t1_chout_addr", 32'(ch_out),    32'h1);
    check("t1_rin_addr",   32'(regmap_in), 0);
    ch_avail = 2'b00;
    tick();
    check("t1_busy_data",  32'(busy),      1);
    check("t1_chout_data", 32'(ch_out),    32'h1);
    check("t1_rin_data",   32'(regmap_in), 0);
    tick();
    check("t1_busy_wr",    32'(busy),      1);
    check("t1_chout_wr",   32'(ch_out),    0);
    check("t1_rin_wr",     32'(regmap_in), 1);
    check("t1_addr_wr",    32'(addr_bus),  32'h12);
    check("t1_wdata_wr",   32'(wdata),     32'hA5);
    tick();
    check("t1_busy_idle",  32'(busy),      0);
    check("t1_rin_idle",   32'(regmap_in), 0);
    check("t1_addr_hold",  32'(addr_bus),  32'h12);
    check("t1_led",        32'(led),       32'(LED_ON));
    check("t1_wr_time",    32'(wr_times.size() > 0 ? wr_times[0] : -1), 32'(t0 + 3));

    // 2: both channels held for four transactions -> 0,1,0,1 every 4 cycles.
    do_reset();
    cur_addr[0] = 8'h30; cur_data[0] = 8'h5A;
    cur_addr[1] = 8'h81; cur_data[1] = 8'hC3;
    exp_q.push_back(mk(0, 8'h30, 8'h5A));
    exp_q.push_back(mk(1, 8'h81, 8'hC3));
    exp_q.push_back(mk(0, 8'h31, 8'h5B));
    exp_q.push_back(mk(1, 8'h82, 8'hC4));
    ch_avail = 2'b11;
    t0 = cyc;
    repeat (13) tick();
    ch_avail = 2'b00;
    repeat (4) tick();
    check("t2_num_writes", 32'(wr_times.size()), 4);
    for (int k = 0; k < 4; k++) begin
      check("t2_wr_time", 32'(k < wr_times.size() ? wr_times[k] : -1), 32'(t0 + 3 + 4*k));
    end
    check("t2_exp_empty", 32'(exp_q.size()), 0);

    // 3: readback and channel-1 request together; readback before any write
    //    goes to channel 0, then channel 1 is granted.
    do_reset();
    cur_addr[1] = 8'h55; cur_data[1] = 8'h99;
    exp_q.push_back(mk(1, 8'h55, 8'h99));
    rb_q.push_back(mk(0, '0, 8'h3C));
    regmap_rdata = 8'h3C;
    regmap_avail = 1'b1;
    ch_avail     = 2'b10;
    tick();
    check("t3_rout",      32'(regmap_out), 1);
    check("t3_busy_ack",  32'(busy),       1);
    check("t3_chout_ack", 32'(ch_out),     0);
    tick();
    check("t3_rout_off",  32'(regmap_out), 0);
    check("t3_ch_in",     32'(ch_in),      32'h1);
    check("t3_tx_data",   32'(ch_tx_data), 32'h3C);
    tick();
    check("t3_busy_idle", 32'(busy),       0);
    check("t3_ch_in_off", 32'(ch_in),      0);
    tick();
    check("t3_grant1",    32'(ch_out),     32'h2);
    ch_avail = 2'b00;
    repeat (3) tick();
    check("t3_exp_empty", 32'(exp_q.size()), 0);
    check("t3_rb_empty",  32'(rb_q.size()),  0);

    // 4: write via channel 1, then readback goes to channel 1 only.
    cur_addr[1] = 8'h66; cur_data[1] = 8'h0F;
    exp_q.push_back(mk(1, 8'h66, 8'h0F));
    ch_avail = 2'b10;
    tick();
    ch_avail = 2'b00;
    repeat (3) tick();
    c0 = in_cnt[0];
    c1 = in_cnt[1];
    rb_q.push_back(mk(1, '0, 8'h7E));
    regmap_rdata = 8'h7E;
    regmap_avail = 1'b1;
    repeat (4) tick();
    check("t4_ch_in1_once",  32'(in_cnt[1] - c1), 1);
    check("t4_ch_in0_quiet", 32'(in_cnt[0] - c0), 0);
    check("t4_rb_empty",     32'(rb_q.size()),    0);
    check("t4_exp_empty",    32'(exp_q.size()),   0);

    // 5: reset during DATA aborts cleanly, then channel 1 is served.
    cur_addr[0] = 8'h21; cur_data[0] = 8'h43;
    ch_avail = 2'b01;
    tick();
    ch_avail = 2'b00;
    tick();
    check("t5_in_data", 32'(ch_out), 32'h1);
    rst = 1'b1;
    tick();
    check("t5_busy",     32'(busy),       0);
    check("t5_ch_out",   32'(ch_out),     0);
    check("t5_ch_in",    32'(ch_in),      0);
    check("t5_rin",      32'(regmap_in),  0);
    check("t5_rout",     32'(regmap_out), 0);
    check("t5_addr_bus", 32'(addr_bus),   0);
    check("t5_wdata",    32'(wdata),      0);
    check("t5_tx_data",  32'(ch_tx_data), 0);
    rst = 1'b0;
    cur_addr[1] = 8'h77; cur_data[1] = 8'hEE;
    exp_q.push_back(mk(1, 8'h77, 8'hEE));
    ch_avail = 2'b10;
    tick();
    check("t5_grant1", 32'(ch_out), 32'h2);
    ch_avail = 2'b00;
    tick();
    tick();
    check("t5_rin_wr", 32'(regmap_in), 1);
    tick();
    check("t5_exp_empty", 32'(exp_q.size()), 0);

    // 6: activity LED over two writes four cycles apart.
    repeat (6) tick();
    cur_addr[0] = 8'h0A; cur_data[0] = 8'hB0;
    exp_q.push_back(mk(0, 8'h0A, 8'hB0));
    exp_q.push_back(mk(0, 8'h0B, 8'hB1));
    ch_avail = 2'b01;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 5) ch_avail = 2'b00;
      check("t6_led", 32'(led), 32'(LED_ON && c >= 4 && c <= 11));
    end
    check("t6_exp_empty", 32'(exp_q.size()), 0);

    repeat (3) tick();
    check("final_exp_empty", 32'(exp_q.size()), 0);
    check("final_rb_empty",  32'(rb_q.size()),  0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
